// File: rtl/gate_response_checker.sv
// Self-test sweep for the two-input gate block: drives a/b through 00..11, samples the
// seven gate outputs after a settle window and counts mismatches. Optional GRC_FAIL_LOG_EN adds a first-failure log.
module gate_response_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic [6:0] resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count
`ifdef GRC_FAIL_LOG_EN
    ,
    output logic [1:0] first_fail_vec,
    output logic [6:0] first_fail_mask,
    output logic       fail_valid
`endif
);

    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      vec, vec_n;
    logic [2:0]      err_n;
    logic            done_n, pass_n;
    logic [6:0]      expected, diff;

`ifdef GRC_FAIL_LOG_EN
    logic [1:0] ffv_n;
    logic [6:0] ffm_n;
    logic       fv_n;
`endif

    // {and, or, nand, nor, not(a), xor, xnor}
    assign expected = {vec[1] & vec[0], vec[1] | vec[0], ~(vec[1] & vec[0]),
                       ~(vec[1] | vec[0]), ~vec[1], vec[1] ^ vec[0], ~(vec[1] ^ vec[0])};
    assign diff     = resp ^ expected;

    assign a_out = vec[1];
    assign b_out = vec[0];
    assign busy  = (state == SETTLE) || (state == SAMPLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            vec       <= 2'b00;
            err_count <= 3'd0;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef GRC_FAIL_LOG_EN
            first_fail_vec  <= 2'b00;
            first_fail_mask <= 7'b0;
            fail_valid      <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            vec       <= vec_n;
            err_count <= err_n;
            done      <= done_n;
            pass      <= pass_n;
`ifdef GRC_FAIL_LOG_EN
            first_fail_vec  <= ffv_n;
            first_fail_mask <= ffm_n;
            fail_valid      <= fv_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vec_n   = vec;
        err_n   = err_count;
        done_n  = done;
        pass_n  = pass;
`ifdef GRC_FAIL_LOG_EN
        ffv_n = first_fail_vec;
        ffm_n = first_fail_mask;
        fv_n  = fail_valid;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    vec_n   = 2'b00;
                    err_n   = 3'd0;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    cnt_n   = CNT_LOAD;
                    state_n = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
`ifdef GRC_FAIL_LOG_EN
                    ffv_n = 2'b00;
                    ffm_n = 7'b0;
                    fv_n  = 1'b0;
`endif
                end
            end
            SETTLE: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) state_n = SAMPLE;
            end
            SAMPLE: begin
                if (diff != 7'b0) begin
                    err_n = (err_count >= 3'd4) ? 3'd4 : err_count + 3'd1;
`ifdef GRC_FAIL_LOG_EN
                    if (!fail_valid) begin
                        ffv_n = vec;
                        ffm_n = diff;
                        fv_n  = 1'b1;
                    end
`endif
                end
                if (vec == 2'd3) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    pass_n  = (err_n == 3'd0);
                end else begin
                    vec_n   = vec + 2'd1;
                    cnt_n   = CNT_LOAD;
                    state_n = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: default-settle instance with fault injection
// on resp, plus a zero-settle instance driven by a golden gate model.
module tb_gate_response_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start0 = 1'b0;
    logic       a_out, b_out, busy, done, pass;
    logic       a0, b0, busy0, done0, pass0;
    logic [2:0] err_count, err0;
    logic [6:0] resp, resp0;
    logic [6:0] flip = 7'b0;
    logic [6:0] stuck = 7'b0;
    int checks = 0;
    int errors = 0;
`ifdef GRC_FAIL_LOG_EN
    logic [1:0] ffv, ffv0;
    logic [6:0] ffm, ffm0;
    logic       fv, fv0;
`endif

    always #5 clk = ~clk;

    function automatic logic [6:0] gate_model(input logic a, input logic b);
        return {a & b, a | b, ~(a & b), ~(a | b), ~a, a ^ b, ~(a ^ b)};
    endfunction

    assign resp  = (gate_model(a_out, b_out) ^ flip) | stuck;
    assign resp0 = gate_model(a0, b0);

    gate_response_checker #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out), .resp(resp),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GRC_FAIL_LOG_EN
        , .first_fail_vec(ffv), .first_fail_mask(ffm), .fail_valid(fv)
`endif
    );

    gate_response_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .resp(resp0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef GRC_FAIL_LOG_EN
        , .first_fail_vec(ffv0), .first_fail_mask(ffm0), .fail_valid(fv0)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start edge counts as edge 0; afterwards we sit 1 time unit past it.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs edges 1..12 after a start edge, checking the vector sequence and done timing.
    task automatic sweep_body(input string name, input logic [2:0] exp_err, input logic exp_pass);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k < 12) begin
                checks++;
                if ({a_out, b_out} !== 2'(k / 3) || done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s edge%0d: ab=%b done=%b busy=%b, want ab=%b done=0 busy=1",
                             name, k, {a_out, b_out}, done, busy, 2'(k / 3));
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || err_count !== exp_err ||
            {a_out, b_out} !== 2'b11) begin
            errors++;
            $display("FAIL %s end: done=%b busy=%b pass=%b err=%0d ab=%b, want 1 0 %b %0d 11",
                     name, done, busy, pass, err_count, {a_out, b_out}, exp_pass, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, pass, a_out, b_out} !== 5'b0 || err_count !== 3'd0 ||
            {busy0, done0, pass0, a0, b0} !== 5'b0 || err0 !== 3'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b pass=%b ab=%b err=%0d, want all 0",
                     busy, done, pass, {a_out, b_out}, err_count);
        end
`ifdef GRC_FAIL_LOG_EN
        checks++;
        if (fv !== 1'b0 || ffv !== 2'b0 || ffm !== 7'b0) begin
            errors++;
            $display("FAIL reset_log: fv=%b ffv=%b ffm=%b, want 0", fv, ffv, ffm);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_golden();
        flip = 7'b0; stuck = 7'b0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || {a_out, b_out} !== 2'b00) begin
            errors++;
            $display("FAIL golden_start: busy=%b ab=%b, want 1 00", busy, {a_out, b_out});
        end
        sweep_body("golden", 3'd0, 1'b1);
`ifdef GRC_FAIL_LOG_EN
        checks++;
        if (fv !== 1'b0) begin
            errors++;
            $display("FAIL golden_log: fv=%b, want 0", fv);
        end
`endif
    endtask

    task automatic test_xor_fault();
        flip = 7'b0000010; stuck = 7'b0;
        pulse_start();
        sweep_body("xor_fault", 3'd4, 1'b0);
`ifdef GRC_FAIL_LOG_EN
        checks++;
        if (fv !== 1'b1 || ffv !== 2'b00 || ffm !== 7'b0000010) begin
            errors++;
            $display("FAIL xor_log: fv=%b ffv=%b ffm=%b, want 1 00 0000010", fv, ffv, ffm);
        end
`endif
        flip = 7'b0;
    endtask

    task automatic test_and_stuck();
        flip = 7'b0; stuck = 7'b1000000;
        pulse_start();
        sweep_body("and_stuck", 3'd3, 1'b0);
`ifdef GRC_FAIL_LOG_EN
        checks++;
        if (fv !== 1'b1 || ffv !== 2'b00 || ffm !== 7'b1000000) begin
            errors++;
            $display("FAIL and_log: fv=%b ffv=%b ffm=%b, want 1 00 1000000", fv, ffv, ffm);
        end
`endif
        stuck = 7'b0;
    endtask

    task automatic test_mid_reset();
        stuck = 7'b1000000;
        pulse_start();
        for (int k = 1; k <= 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, pass, a_out, b_out} !== 5'b0 || err_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b pass=%b ab=%b err=%0d, want all 0",
                     busy, done, pass, {a_out, b_out}, err_count);
        end
        stuck = 7'b0;
        tick();
        pulse_start();
        sweep_body("after_reset", 3'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            start = (k == 3 || k == 7);
            tick();
            start = 1'b0;
            if (k < 12) begin
                checks++;
                if (done !== 1'b0 || {a_out, b_out} !== 2'(k / 3)) begin
                    errors++;
                    $display("FAIL ignore_start edge%0d: done=%b ab=%b, want 0 %b",
                             k, done, {a_out, b_out}, 2'(k / 3));
                end
            end
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start end: done=%b pass=%b, want 1 1", done, pass);
        end
        flip = 7'b0000010;
        pulse_start();
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1 || err_count !== 3'd0 ||
            {a_out, b_out} !== 2'b00) begin
            errors++;
            $display("FAIL restart: done=%b pass=%b busy=%b err=%0d ab=%b, want 0 0 1 0 00",
                     done, pass, busy, err_count, {a_out, b_out});
        end
        sweep_body("restart", 3'd4, 1'b0);
        flip = 7'b0;
    endtask

    task automatic test_settle_zero();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) begin
                checks++;
                if ({a0, b0} !== 2'(k - 1) || done0 !== 1'b0 || busy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL settle0 edge%0d: ab=%b done=%b busy=%b, want %b 0 1",
                             k - 1, {a0, b0}, done0, busy0, 2'(k - 1));
                end
            end
            tick();
        end
        checks++;
        if (done0 !== 1'b1 || pass0 !== 1'b1 || err0 !== 3'd0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL settle0 end: done=%b pass=%b err=%0d busy=%b, want 1 1 0 0",
                     done0, pass0, err0, busy0);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_xor_fault();
        test_and_stuck();
        test_mid_reset();
        test_back_to_back();
        test_settle_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
